// File: rtl/cpu_pkg.sv
// Purpose: shared pipeline types and constants for the decode/execute boundary.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_W = 5;

    // Register number that never creates a dependency (hardwired zero register).
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // Decoded control bundle; RegWrite is the MSB, ALUOp the low three bits.
    typedef struct packed {
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemToReg;
        logic       ALUSrc;
        logic [2:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Purpose: load-use hazard detect between the EX-slot load and the ID-slot consumer.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; lu is consumed by id_ex_stage to stall upstream.
//
// Ports:
//   id_ex_valid, id_ex_mem_read, id_ex_rw : instruction currently in EX
//   if_id_ra, if_id_rb, if_id_uses_rb,
//   if_id_valid                           : instruction currently in ID
//   lu                                    : ID instruction needs the EX load's result
import cpu_pkg::*;

module hazard_detect (
    input  logic             id_ex_valid,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rw,
    input  logic [REG_W-1:0] if_id_ra,
    input  logic [REG_W-1:0] if_id_rb,
    input  logic             if_id_uses_rb,
    input  logic             if_id_valid,
    output logic             lu
);

    logic ex_is_load;
    logic ra_match;
    logic rb_match;

    // The zero register is excluded so a load to it never stalls, matching
    // the forwarding unit which also never forwards to/from it.
    assign ex_is_load = id_ex_valid && id_ex_mem_read && (id_ex_rw != ZERO_REG);
    assign ra_match   = (id_ex_rw == if_id_ra);
    // Rb only counts when the instruction reads it as a register, not an immediate.
    assign rb_match   = if_id_uses_rb && (id_ex_rw == if_id_rb);

    assign lu = ex_is_load && (ra_match || rb_match) && if_id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with load-use bubble, branch flush and MEM-hold freeze.
// Latency: 1 cycle IF_ID -> ID_EX; PCWrite/IF_ID_Write are combinational (0 cycles).
// Backpressure: Hold freezes this register and deasserts PCWrite/IF_ID_Write; a load-use
//               inserts one bubble and stalls upstream for that one cycle; flush never stalls.
//
// Ports:
//   clk, reset                 : pipeline clock, async active-high reset
//   IF_ID_*                    : decoded instruction from ID (regs, ctrl, data, valid)
//   Flush                      : branch taken in EX, ID instruction is wrong-path
//   Hold                       : MEM busy, freeze this stage and upstream
//   ID_EX_*                    : registered instruction for EX and the forwarding unit
//   PCWrite, IF_ID_Write       : upstream enables (active high)
//   StallCount                 : saturating number of load-use bubbles inserted
import cpu_pkg::*;

module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  IF_ID_Ra,
    input  logic [REG_W-1:0]  IF_ID_Rb,
    input  logic [REG_W-1:0]  IF_ID_Rw,
    input  logic              IF_ID_UsesRb,
    input  logic              IF_ID_Valid,
    input  ctrl_t             IF_ID_Ctrl,
    input  logic [DATA_W-1:0] IF_ID_Da,
    input  logic [DATA_W-1:0] IF_ID_Db,
    input  logic [DATA_W-1:0] IF_ID_Imm,
    input  logic              Flush,
    input  logic              Hold,
    output logic [REG_W-1:0]  ID_EX_Ra,
    output logic [REG_W-1:0]  ID_EX_Rb,
    output logic [REG_W-1:0]  ID_EX_Rw,
    output ctrl_t             ID_EX_Ctrl,
    output logic [DATA_W-1:0] ID_EX_Da,
    output logic [DATA_W-1:0] ID_EX_Db,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic              ID_EX_Valid,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic lu;
    logic flush_pend;
    logic kill;        // current or remembered flush wins over everything but Hold
    logic upstream_en;

    hazard_detect u_hazard_detect (
        .id_ex_valid    (ID_EX_Valid),
        .id_ex_mem_read (ID_EX_Ctrl.MemRead),
        .id_ex_rw       (ID_EX_Rw),
        .if_id_ra       (IF_ID_Ra),
        .if_id_rb       (IF_ID_Rb),
        .if_id_uses_rb  (IF_ID_UsesRb),
        .if_id_valid    (IF_ID_Valid),
        .lu             (lu)
    );

    assign kill = Flush || flush_pend;

    // A flush must not stall: fetch has to overwrite the wrong-path instruction,
    // so a load-use against it is irrelevant.
    assign upstream_en = ~(Hold | (lu & ~kill));
    assign PCWrite     = upstream_en;
    assign IF_ID_Write = upstream_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ID_EX_Ra    <= '0;
            ID_EX_Rb    <= '0;
            ID_EX_Rw    <= '0;
            ID_EX_Ctrl  <= CTRL_NOP;
            ID_EX_Da    <= '0;
            ID_EX_Db    <= '0;
            ID_EX_Imm   <= '0;
            ID_EX_Valid <= 1'b0;
            flush_pend  <= 1'b0;
            StallCount  <= '0;
        end else if (Hold) begin
            // Frozen; remember a flush seen while frozen so it still takes
            // effect (exactly once) when the hold releases.
            if (Flush) begin
                flush_pend <= 1'b1;
            end
        end else if (kill || lu) begin
            ID_EX_Ra    <= '0;
            ID_EX_Rb    <= '0;
            ID_EX_Rw    <= '0;
            ID_EX_Ctrl  <= CTRL_NOP;
            ID_EX_Da    <= '0;
            ID_EX_Db    <= '0;
            ID_EX_Imm   <= '0;
            ID_EX_Valid <= 1'b0;
            flush_pend  <= 1'b0;
            // Only genuine load-use bubbles are counted, not flush bubbles.
            if (!kill && (StallCount != CNT_MAX)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end else begin
            ID_EX_Ra    <= IF_ID_Ra;
            ID_EX_Rb    <= IF_ID_Rb;
            ID_EX_Rw    <= IF_ID_Rw;
            ID_EX_Ctrl  <= IF_ID_Ctrl;
            ID_EX_Da    <= IF_ID_Da;
            ID_EX_Db    <= IF_ID_Db;
            ID_EX_Imm   <= IF_ID_Imm;
            ID_EX_Valid <= IF_ID_Valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose: self-checking bench for id_ex_stage (instruction-slot model + directed vectors).
// Latency: n/a.
// Backpressure: n/a.
import cpu_pkg::*;

module tb_id_ex_stage;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    in_ra = '0, in_rb = '0, in_rw = '0;
    logic          in_usesrb = 1'b0, in_valid = 1'b0;
    ctrl_t         in_ctrl = '0;
    logic [DW-1:0] in_da = '0, in_db = '0, in_imm = '0;
    logic          flush = 1'b0, hold = 1'b0;

    logic [4:0]    o_ra, o_rb, o_rw;
    ctrl_t         o_ctrl;
    logic [DW-1:0] o_da, o_db, o_imm;
    logic          o_valid, o_pcwrite, o_ifidwrite;
    logic [CW-1:0] o_cnt;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_Ra(in_ra), .IF_ID_Rb(in_rb), .IF_ID_Rw(in_rw),
        .IF_ID_UsesRb(in_usesrb), .IF_ID_Valid(in_valid), .IF_ID_Ctrl(in_ctrl),
        .IF_ID_Da(in_da), .IF_ID_Db(in_db), .IF_ID_Imm(in_imm),
        .Flush(flush), .Hold(hold),
        .ID_EX_Ra(o_ra), .ID_EX_Rb(o_rb), .ID_EX_Rw(o_rw), .ID_EX_Ctrl(o_ctrl),
        .ID_EX_Da(o_da), .ID_EX_Db(o_db), .ID_EX_Imm(o_imm), .ID_EX_Valid(o_valid),
        .PCWrite(o_pcwrite), .IF_ID_Write(o_ifidwrite), .StallCount(o_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: the instruction occupying the EX slot ----------------
    typedef struct {
        bit        valid;
        bit [4:0]  ra, rb, rw;
        bit [7:0]  ctrl;
        bit [63:0] da, db, imm;
    } slot_t;

    slot_t ex_slot;      // empty slot == bubble
    bit    m_pend;       // a flush happened during a hold and is still owed
    int    m_stalls;     // number of load-use bubbles, unbounded

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.ra = 0; s.rb = 0; s.rw = 0; s.ctrl = 0;
        s.da = 0; s.db = 0; s.imm = 0;
        return s;
    endfunction

    // ID instruction depends on a non-zero-destination load sitting in EX
    function automatic bit id_needs_ex_load();
        ctrl_t c;
        bit reads_dest;
        c = ctrl_t'(ex_slot.ctrl);
        reads_dest = (in_ra == ex_slot.rw) || (in_usesrb && in_rb == ex_slot.rw);
        return ex_slot.valid && c.MemRead && ex_slot.rw != 0 && reads_dest && in_valid;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_slot  = empty_slot();
            m_pend   = 0;
            m_stalls = 0;
        end else if (hold) begin
            m_pend = m_pend | flush;
        end else if (flush || m_pend) begin
            ex_slot = empty_slot();
            m_pend  = 0;
        end else if (id_needs_ex_load()) begin
            ex_slot  = empty_slot();
            m_stalls = m_stalls + 1;
        end else begin
            ex_slot.valid = in_valid; ex_slot.ra = in_ra; ex_slot.rb = in_rb;
            ex_slot.rw = in_rw; ex_slot.ctrl = in_ctrl; ex_slot.da = in_da;
            ex_slot.db = in_db; ex_slot.imm = in_imm;
        end
    end

    // Single compare process, mid-cycle every cycle.
    always @(negedge clk) begin
        bit stall;
        int sat;
        stall = hold || (id_needs_ex_load() && !flush && !m_pend);
        sat   = (m_stalls > 15) ? 15 : m_stalls;
        chk("m_ra",    64'(o_ra),    64'(ex_slot.ra));
        chk("m_rb",    64'(o_rb),    64'(ex_slot.rb));
        chk("m_rw",    64'(o_rw),    64'(ex_slot.rw));
        chk("m_ctrl",  64'(o_ctrl),  64'(ex_slot.ctrl));
        chk("m_da",    o_da,         ex_slot.da);
        chk("m_db",    o_db,         ex_slot.db);
        chk("m_imm",   o_imm,        ex_slot.imm);
        chk("m_valid", 64'(o_valid), 64'(ex_slot.valid));
        chk("m_pcw",   64'(o_pcwrite),   64'(!stall));
        chk("m_ifidw", 64'(o_ifidwrite), 64'(!stall));
        chk("m_cnt",   64'(o_cnt),   64'(sat));
    end

    // ---------------- stimulus helpers ----------------
    localparam ctrl_t LDUR = '{RegWrite:1'b1, MemRead:1'b1, MemWrite:1'b0, MemToReg:1'b1,
                               ALUSrc:1'b1, ALUOp:3'b000};
    localparam ctrl_t ADD  = '{RegWrite:1'b1, MemRead:1'b0, MemWrite:1'b0, MemToReg:1'b0,
                               ALUSrc:1'b0, ALUOp:3'b010};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [4:0] rw);
        in_valid = 1; in_ctrl = LDUR; in_ra = 5'd2; in_rb = 5'd0; in_rw = rw;
        in_usesrb = 0; in_da = 64'h1000; in_db = 64'h0; in_imm = 64'h10;
    endtask

    task automatic set_add(input logic [4:0] ra, input logic [4:0] rb, input logic ub);
        in_valid = 1; in_ctrl = ADD; in_ra = ra; in_rb = rb; in_rw = 5'd9;
        in_usesrb = ub; in_da = 64'hA5A5_0000_1111_2222; in_db = 64'h0123_4567_89AB_CDEF;
        in_imm = 64'h0;
    endtask

    initial begin
        #1 reset = 1;
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_cnt",   64'(o_cnt),   64'd0);
        chk("rst_pcw",   64'(o_pcwrite), 64'd1);
        cyc();
        reset = 0;

        // Reset mid-stream
        set_ld(5'd5);
        cyc();
        chk("ld_rw", 64'(o_rw), 64'd5);
        chk("ld_ctrl", 64'(o_ctrl), 64'hD8);
        set_add(5'd5, 5'd6, 1);
        #1 reset = 1;
        #1;
        chk("mid_rst_rw",    64'(o_rw),    64'd0);
        chk("mid_rst_ctrl",  64'(o_ctrl),  64'd0);
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_cnt",   64'(o_cnt),   64'd0);
        chk("mid_rst_pcw",   64'(o_pcwrite), 64'd1);
        reset = 0;

        // Load-use on Ra
        set_ld(5'd5);
        cyc();
        set_add(5'd5, 5'd6, 1);
        #1;
        chk("lu_pcw",   64'(o_pcwrite),   64'd0);
        chk("lu_ifidw", 64'(o_ifidwrite), 64'd0);
        cyc();
        chk("lu_bub_ctrl",  64'(o_ctrl),  64'd0);
        chk("lu_bub_valid", 64'(o_valid), 64'd0);
        chk("lu_bub_cnt",   64'(o_cnt),   64'd1);
        chk("lu_bub_pcw",   64'(o_pcwrite), 64'd1);
        cyc();
        chk("lu_use_ra",    64'(o_ra),    64'd5);
        chk("lu_use_valid", 64'(o_valid), 64'd1);
        chk("lu_use_pcw",   64'(o_pcwrite), 64'd1);

        // Zero register never hazards
        set_ld(5'd0);
        cyc();
        set_add(5'd0, 5'd1, 1);
        #1 chk("zr_pcw", 64'(o_pcwrite), 64'd1);
        cyc();
        chk("zr_valid", 64'(o_valid), 64'd1);
        chk("zr_cnt",   64'(o_cnt),   64'd1);

        // Rb gating
        set_ld(5'd7);
        cyc();
        set_add(5'd1, 5'd7, 0);
        #1 chk("rb_off_pcw", 64'(o_pcwrite), 64'd1);
        in_usesrb = 1;
        #1 chk("rb_on_pcw", 64'(o_pcwrite), 64'd0);
        cyc();
        chk("rb_cnt",   64'(o_cnt),   64'd2);
        chk("rb_valid", 64'(o_valid), 64'd0);

        // Flush during a 3-cycle hold
        set_ld(5'd3);
        cyc();
        hold = 1; flush = 1;
        set_add(5'd1, 5'd2, 1);
        #1 chk("hold_pcw", 64'(o_pcwrite), 64'd0);
        cyc();
        flush = 0;
        chk("hold1_rw", 64'(o_rw), 64'd3);
        cyc();
        chk("hold2_rw", 64'(o_rw), 64'd3);
        cyc();
        chk("hold3_ctrl", 64'(o_ctrl), 64'hD8);
        hold = 0;
        set_add(5'd3, 5'd2, 1);     // would be load-use, owed flush wins
        #1 chk("pend_pcw", 64'(o_pcwrite), 64'd1);
        cyc();
        chk("pend_bub_valid", 64'(o_valid), 64'd0);
        chk("pend_bub_cnt",   64'(o_cnt),   64'd2);
        cyc();
        chk("after_pend_ra",    64'(o_ra),    64'd3);
        chk("after_pend_valid", 64'(o_valid), 64'd1);

        // Flush together with load-use
        set_ld(5'd4);
        cyc();
        set_add(5'd4, 5'd0, 0);
        flush = 1;
        #1 chk("fl_lu_pcw", 64'(o_pcwrite), 64'd1);
        cyc();
        flush = 0;
        chk("fl_lu_valid", 64'(o_valid), 64'd0);
        chk("fl_lu_cnt",   64'(o_cnt),   64'd2);

        // Counter saturation: 17 load-use stalls
        for (int i = 0; i < 17; i++) begin
            set_ld(5'd8);
            cyc();
            set_add(5'd8, 5'd0, 0);
            cyc();
            if (i == 12) chk("sat_reach", 64'(o_cnt), 64'd15);
        end
        chk("sat_hold", 64'(o_cnt), 64'd15);
        in_valid = 0;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection, bubble insertion, branch flush and memory-hold freeze. It captures decoded operands and control from the ID stage and drives the `ID_EX_*` fields consumed by EX and by the forwarding unit (`ID_EX_Ra`, `ID_EX_Rb`). It also returns stall control (`PCWrite`, `IF_ID_Write`) to the fetch and decode stages.

## Interface
- `DATA_W`, 64, operand and immediate width.
- `CNT_W`, 16, width of the load-use stall counter.
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `IF_ID_Ra`, `IF_ID_Rb`, `IF_ID_Rw` in 5 each: source and destination register numbers of the instruction in ID.
- `IF_ID_UsesRb` in 1: the ID instruction reads Rb as a register (not an immediate).
- `IF_ID_Valid` in 1: the ID slot holds a real instruction.
- `IF_ID_Ctrl` in `ctrl_t` (8): `RegWrite`, `MemRead`, `MemWrite`, `MemToReg`, `ALUSrc`, `ALUOp[2:0]`.
- `IF_ID_Da`, `IF_ID_Db`, `IF_ID_Imm` in DATA_W each: register-file read data and the extended immediate.
- `Flush` in 1: branch taken in EX; the ID instruction is wrong-path.
- `Hold` in 1: MEM stage busy; freeze this register and everything upstream.
- `ID_EX_Ra`, `ID_EX_Rb`, `ID_EX_Rw` out 5 each: registered register numbers.
- `ID_EX_Ctrl` out `ctrl_t`: registered control.
- `ID_EX_Da`, `ID_EX_Db`, `ID_EX_Imm` out DATA_W each: registered data.
- `ID_EX_Valid` out 1: the EX slot holds a real instruction.
- `PCWrite`, `IF_ID_Write` out 1 each: active-high enables for the PC and the IF/ID register.
- `StallCount` out CNT_W: saturating count of load-use bubbles.

## Operation
- Load-use hazard (`lu`) is asserted when all of the following hold:
  - `ID_EX_Valid` and `ID_EX_Ctrl.MemRead`;
  - `ID_EX_Rw != ZERO_REG`;
  - `ID_EX_Rw == IF_ID_Ra`, or (`IF_ID_UsesRb` and `ID_EX_Rw == IF_ID_Rb`);
  - `IF_ID_Valid`.
- A bubble is: `ID_EX_Ctrl` = 0, `ID_EX_Valid` = 0. Register numbers and data are don't-care but must be driven to 0.
- Pending flush: the `flush_pend` flag is set when `Flush` arrives while `Hold` = 1. It is cleared when the bubble it caused is loaded.
- Per-edge action, highest priority first:
  - `reset`: all registers 0, `flush_pend` = 0, `StallCount` = 0.
  - `Hold`: all registers keep their value. If `Flush`, set `flush_pend`.
  - `Flush` or `flush_pend`: load a bubble and clear `flush_pend`. The load-use condition is ignored and the counter does not increment.
  - `lu`: load a bubble and increment `StallCount`, saturating at all-ones.
  - Otherwise: load all `IF_ID_*` fields; `ID_EX_Valid` is set to `IF_ID_Valid`.
- Stall outputs (combinational): `PCWrite` = `IF_ID_Write` = ~(`Hold` | (`lu` & ~`Flush` & ~`flush_pend`)).
- A flush never stalls upstream, because the wrong-path instruction must be overwritten by fetch.
- The register number `ZERO_REG` never causes a hazard, matching the forwarding unit's zero-register exclusion.

## Timing
- Capture latency is 1 cycle: IF_ID values present at edge n appear on `ID_EX_*` after edge n.
- `PCWrite` and `IF_ID_Write` respond in the same cycle to `Hold`, `Flush` and the current `ID_EX`/`IF_ID` contents. There is no registered delay.
- A load-use stall lasts exactly 1 cycle:
  - After the bubble, `ID_EX` no longer holds the load, so `lu` drops.
  - The consumer enters EX the next cycle, and the forwarding unit supplies the load data from MEM/WB.
- Back-to-back dependent loads cost 1 bubble each.
- Reset values: all `ID_EX_*` = 0, `ID_EX_Valid` = 0, `StallCount` = 0. `PCWrite` = `IF_ID_Write` = ~`Hold` while in reset.
- Asserting `reset` mid-stall or mid-hold discards `flush_pend` and any in-flight instruction asynchronously.
- `Flush` held across several Hold cycles results in exactly one bubble.

## Structure
- Package `cpu_pkg` holds:
  - `ctrl_t` (packed struct, fields in the order listed above);
  - `REG_W` = 5;
  - `ZERO_REG` = 5'd0, shared with the forwarding unit;
  - `CTRL_NOP` = all-zero `ctrl_t`.
- Sub-module `hazard_detect`: purely combinational. It computes `lu` from the `ID_EX_Valid`, `MemRead` and `Rw` signals and the `IF_ID_Ra`/`Rb`/`UsesRb`/`Valid` signals.
- The register, flush-pending and counter logic stay in `id_ex_stage`.

## Test plan
- **Reset mid-stream:** LDUR with `Rw=5`, `MemRead=1` loaded, then `reset` pulsed between edges. Required: all `ID_EX_*` = 0 immediately, `ID_EX_Valid` = 0, `StallCount` = 0, `PCWrite` = 1.
- **Load-use on Ra:** `ID_EX` = LDUR `Rw=5`, ID = ADD `Ra=5`. Required:
  - cycle n: `PCWrite` = `IF_ID_Write` = 0;
  - after edge n: `ID_EX_Ctrl` = 0, `Valid` = 0, `StallCount` = 1;
  - after edge n+1: `ID_EX_Ra` = 5, `Valid` = 1, and the stall outputs are back to 1.
- **Zero register and Rb gating:** LDUR `Rw=0` with ID `Ra=0` gives no stall. LDUR `Rw=7` with ID `Rb=7`: `UsesRb=0` gives no stall; `UsesRb=1` gives a stall.
- **Flush during hold:** `Hold`=1 for 3 cycles, with `Flush`=1 only in the first cycle. Required:
  - outputs frozen throughout the hold;
  - first edge after `Hold` falls loads a bubble;
  - next edge loads the `IF_ID` fields normally.
- **Flush with load-use in the same cycle:** `Flush`=1 while `lu` is true. Required: `PCWrite` = 1, a bubble is loaded, `StallCount` unchanged.
- **Counter saturation:** with `CNT_W`=4, drive 17 load-use stalls. Required: `StallCount` reaches 15 and stays at 15.
